matrix_store: RTL and testbench

Playfield storage and merge stage that sits directly downstream of the piece-commit executor. It holds the `height_p` × `width_p` occupancy matrix and accepts a committed 4×4 shape at a point. It ORs that shape into the matrix one shape row per cycle and, when compiled in, clears full lines with shift-down. It also serves a combinational row-read port to the collision and render logic.

---
 rtl/matrix_store.sv | 161 ++++++++++++++++
 tb/tb_matrix_store.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_store.sv
// Playfield occupancy matrix. It merges a committed 4x4 shape one row per cycle and serves a
// combinational row-read port. Define MATRIX_STORE_LINE_CLEAR_EN to add the full-line clear/shift-down scan.
package matrix_store_pkg;
  typedef struct packed {
    logic signed [7:0] x;
    logic signed [7:0] y;
  } point_t;
endpackage

module matrix_store
  import matrix_store_pkg::*;
#(
  parameter int width_p  = 16,
  parameter int height_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  point_t                      write_addr_i,
  input  logic [3:0][3:0]             write_data_i,
  input  logic                        write_v_i,
  output logic                        is_ready_o,
  input  logic [$clog2(height_p)-1:0] rd_row_addr_i,
  output logic [width_p-1:0]          rd_row_data_o,
  output logic                        clear_v_o,
  output logic [2:0]                  lines_cleared_o,
  output logic                        overflow_o
);

  localparam int AW = $clog2(height_p);
  // Coordinate math is done in 10 bits so x+c / y+k never wrap for 8-bit signed origins.
  localparam int CW = 10;

`ifdef MATRIX_STORE_LINE_CLEAR_EN
  typedef enum logic [1:0] {eIDLE = 2'd0, eMERGE = 2'd1, eSCAN = 2'd2, eDONE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {eIDLE = 2'd0, eMERGE = 2'd1, eDONE = 2'd3} state_e;
`endif

  state_e                                 state_q, state_d;
  point_t                                 addr_q, addr_d;
  logic [3:0][3:0]                        data_q, data_d;
  logic [1:0]                             k_q, k_d;
  logic [height_p-1:0][width_p-1:0]       rows_q, rows_d;
  logic                                   ovf_q, ovf_d;
`ifdef MATRIX_STORE_LINE_CLEAR_EN
  logic [AW-1:0]                          p_q, p_d;
  logic [2:0]                             cnt_q, cnt_d;
`endif

  logic signed [CW-1:0] xs, ys;
  logic [3:0]           row_bits;
  logic [width_p-1:0]   mask;

  // Shape row k placed at columns x..x+3; columns outside the matrix simply never match.
  always_comb begin
    xs       = {{(CW-8){addr_q.x[7]}}, addr_q.x};
    ys       = {{(CW-8){addr_q.y[7]}}, addr_q.y} + CW'(k_q);
    row_bits = data_q[k_q];
    mask     = '0;
    for (int j = 0; j < width_p; j++)
      for (int c = 0; c < 4; c++)
        if (row_bits[c] && ((xs + CW'(c)) == CW'(j))) mask[j] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    k_d     = k_q;
    rows_d  = rows_q;
    ovf_d   = ovf_q;
`ifdef MATRIX_STORE_LINE_CLEAR_EN
    p_d     = p_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      eIDLE: begin
        if (write_v_i) begin
          addr_d  = write_addr_i;
          data_d  = write_data_i;
          k_d     = 2'd0;
`ifdef MATRIX_STORE_LINE_CLEAR_EN
          cnt_d   = 3'd0;
`endif
          state_d = eMERGE;
        end
      end
      eMERGE: begin
        if (ys[CW-1]) begin
          if (row_bits != 4'd0) ovf_d = 1'b1;
        end else begin
          for (int i = 0; i < height_p; i++)
            if (ys == CW'(i)) rows_d[i] = rows_q[i] | mask;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
`ifdef MATRIX_STORE_LINE_CLEAR_EN
          p_d     = AW'(height_p - 1);
          state_d = eSCAN;
`else
          state_d = eDONE;
`endif
        end
      end
`ifdef MATRIX_STORE_LINE_CLEAR_EN
      eSCAN: begin
        // A cleared row keeps p in place so the row shifted into it gets checked too.
        if (&rows_q[p_q]) begin
          for (int i = 1; i < height_p; i++)
            if (AW'(i) <= p_q) rows_d[i] = rows_q[i-1];
          rows_d[0] = '0;
          if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
        end else if (p_q == '0) begin
          state_d = eDONE;
        end else begin
          p_d = p_q - AW'(1);
        end
      end
`endif
      eDONE:   state_d = eIDLE;
      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= eIDLE;
      addr_q  <= '0;
      data_q  <= '0;
      k_q     <= '0;
      rows_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef MATRIX_STORE_LINE_CLEAR_EN
      p_q     <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      k_q     <= k_d;
      rows_q  <= rows_d;
      ovf_q   <= ovf_d;
`ifdef MATRIX_STORE_LINE_CLEAR_EN
      p_q     <= p_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign is_ready_o    = reset_n_i && (state_q == eIDLE);
  assign clear_v_o     = reset_n_i && (state_q == eDONE);
  assign overflow_o    = ovf_q;
  assign rd_row_data_o = (32'(rd_row_addr_i) >= 32'(height_p)) ? '1 : rows_q[rd_row_addr_i];
`ifdef MATRIX_STORE_LINE_CLEAR_EN
  assign lines_cleared_o = cnt_q;
`else
  assign lines_cleared_o = 3'd0;
`endif

endmodule

// File: tb/tb_matrix_store.sv
// Directed plus random writes into matrix_store, checked against a row-array reference model.
module tb_matrix_store;
  import matrix_store_pkg::*;

  localparam int W  = 16;
  localparam int H  = 32;
  localparam int H2 = 20;

  logic            clk = 1'b0;
  logic            reset_n_i;
  point_t          write_addr_i;
  logic [3:0][3:0] write_data_i;
  logic            write_v_i;
  logic            is_ready_o;
  logic [4:0]      rd_row_addr_i;
  logic [W-1:0]    rd_row_data_o;
  logic            clear_v_o;
  logic [2:0]      lines_cleared_o;
  logic            overflow_o;

  point_t          addr2;
  logic [3:0][3:0] data2;
  logic            wv2;
  logic            rdy2, clr2, ovf2;
  logic [4:0]      rd2_addr;
  logic [W-1:0]    rd2_data;
  logic [2:0]      lc2;

  always #5 clk = ~clk;

  matrix_store #(.width_p(W), .height_p(H)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .write_addr_i(write_addr_i), .write_data_i(write_data_i),
    .write_v_i(write_v_i), .is_ready_o(is_ready_o), .rd_row_addr_i(rd_row_addr_i),
    .rd_row_data_o(rd_row_data_o), .clear_v_o(clear_v_o), .lines_cleared_o(lines_cleared_o),
    .overflow_o(overflow_o));

  // Short matrix so out-of-range read addresses are reachable.
  matrix_store #(.width_p(W), .height_p(H2)) dut2 (
    .clk_i(clk), .reset_n_i(reset_n_i), .write_addr_i(addr2), .write_data_i(data2),
    .write_v_i(wv2), .is_ready_o(rdy2), .rd_row_addr_i(rd2_addr),
    .rd_row_data_o(rd2_data), .clear_v_o(clr2), .lines_cleared_o(lc2), .overflow_o(ovf2));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m [H];
  logic         movf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < H; i++) m[i] = '0;
    movf = 1'b0;
  endtask

  // Returns raw number of full rows removed (drives scan time) and the saturated report.
  task automatic model_write(input int x, input int y, input logic [3:0][3:0] d,
                             output int nraw, output int nsat);
    logic [W-1:0] t [H];
    int dst;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (d[r][c]) begin
          if (y + r < 0) movf = 1'b1;
          else if (y + r < H && x + c >= 0 && x + c < W) m[y+r][x+c] = 1'b1;
        end
    nraw = 0;
`ifdef MATRIX_STORE_LINE_CLEAR_EN
    dst = H - 1;
    for (int i = H - 1; i >= 0; i--)
      if (m[i] != {W{1'b1}}) begin t[dst] = m[i]; dst--; end
      else nraw++;
    for (int i = dst; i >= 0; i--) t[i] = '0;
    m = t;
`else
    dst = 0;
    t[0] = '0;
`endif
    nsat = (nraw > 4) ? 4 : nraw;
  endtask

  task automatic check_rows(input string tag);
    for (int i = 0; i < H; i++) begin
      rd_row_addr_i = 5'(i);
      #1;
      chk($sformatf("%s_row%0d", tag, i), 32'(rd_row_data_o), 32'(m[i]));
    end
  endtask

  task automatic do_write(input string tag, input int x, input int y,
                          input logic [3:0][3:0] d, input bit spam);
    int nraw, nsat, lat, cyc;
    bit seen;
    cyc = 0;
    while (!is_ready_o && cyc < 200) begin @(negedge clk); cyc++; end
    chk({tag, "_ready_in"}, 32'(is_ready_o), 32'd1);
    @(negedge clk);
    write_addr_i.x = 8'(x);
    write_addr_i.y = 8'(y);
    write_data_i   = d;
    write_v_i      = 1'b1;
    @(posedge clk);
    #1;
    if (spam) begin
      write_addr_i = '0;
      write_data_i = '1;
    end else write_v_i = 1'b0;
    model_write(x, y, d, nraw, nsat);
    lat = 4;
`ifdef MATRIX_STORE_LINE_CLEAR_EN
    lat = 4 + H + nraw;
`endif
    @(negedge clk);
    chk({tag, "_ready_low"}, 32'(is_ready_o), 32'd0);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      if (clear_v_o) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
        if (cyc == 3) write_v_i = 1'b0;
      end
    end
    write_v_i = 1'b0;
    chk({tag, "_clear_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_lines"}, 32'(lines_cleared_o), 32'(nsat));
    @(negedge clk);
    chk({tag, "_clear_pulse"}, 32'(clear_v_o), 32'd0);
    chk({tag, "_ready_out"}, 32'(is_ready_o), 32'd1);
    chk({tag, "_overflow"}, 32'(overflow_o), 32'(movf));
    check_rows(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_forced_low", 32'(is_ready_o), 32'd0);
    reset_n_i = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_ready_after", 32'(is_ready_o), 32'd1);
  endtask

  initial begin
    logic [3:0][3:0] d;
    reset_n_i     = 1'b0;
    write_addr_i  = '0;
    write_data_i  = '0;
    write_v_i     = 1'b0;
    rd_row_addr_i = '0;
    addr2 = '0; data2 = '0; wv2 = 1'b0; rd2_addr = '0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(is_ready_o), 32'd0);
    chk("rst_clear_v", 32'(clear_v_o), 32'd0);
    chk("rst_lines", 32'(lines_cleared_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    check_rows("rst");
    reset_n_i = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(is_ready_o), 32'd1);

    rd2_addr = 5'd20; #1 chk("rd_oob_20", 32'(rd2_data), 32'hFFFF);
    rd2_addr = 5'd31; #1 chk("rd_oob_31", 32'(rd2_data), 32'hFFFF);
    rd2_addr = 5'd19; #1 chk("rd_last_row", 32'(rd2_data), 32'h0);

    d = '0; d[0] = 4'hF;
    do_write("row30", 0, 30, d, 0);
    do_write("fill4", 4, 31, d, 0);
    do_write("fill8", 8, 31, d, 0);
    do_write("fill12", 12, 31, d, 0);
    do_write("iclear", 0, 31, d, 0);

    do_write("clipx", 14, 5, d, 0);
    d = '0; d[0] = 4'hF; d[1] = 4'h1;
    do_write("ovf", 3, -1, d, 0);
    d = '0;
    do_write("ovf_sticky", 0, 12, d, 0);
    apply_reset();
    chk("ovf_cleared", 32'(overflow_o), 32'd0);

    d = '0; d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h4; d[3] = 4'h8;
    do_write("pre24", 0, 24, d, 0);
    d = '1;
    do_write("blk4", 4, 28, d, 0);
    do_write("blk8", 8, 28, d, 0);
    do_write("blk12", 12, 28, d, 0);
    d = '0; for (int r = 0; r < 4; r++) d[r] = 4'b1110;
    do_write("blk1", 0, 28, d, 0);
    d = '0; for (int r = 0; r < 4; r++) d[r] = 4'b0001;
    do_write("vert4", 0, 28, d, 0);

    d = '0; d[0] = 4'b0110; d[1] = 4'b0110;
    do_write("spam", 5, 10, d, 1);

    // Reset during the second merge cycle aborts the write.
    @(negedge clk);
    write_addr_i.x = 8'd0; write_addr_i.y = 8'd10; write_data_i = '1; write_v_i = 1'b1;
    @(posedge clk);
    #1 write_v_i = 1'b0;
    @(posedge clk);
    #1 reset_n_i = 1'b0;
    @(negedge clk);
    chk("midrst_ready_low", 32'(is_ready_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_no_clear", 32'(clear_v_o), 32'd0);
    reset_n_i = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_ready", 32'(is_ready_o), 32'd1);
    chk("midrst_no_clear2", 32'(clear_v_o), 32'd0);
    chk("midrst_ovf", 32'(overflow_o), 32'd0);
    check_rows("midrst");

    for (int n = 0; n < 20; n++) begin
      int rx, ry;
      rx = int'($urandom_range(0, 19)) - 3;
      ry = int'($urandom_range(0, 36)) - 4;
      d  = 16'($urandom);
      do_write($sformatf("rnd%0d", n), rx, ry, d, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
